tt_sel_seq: RTL and testbench

Sequencer that drives the three control-high select pins (`ctrl_sel_rst_n`, `ctrl_sel_inc`, `ctrl_ena`) of the TinyTapeout chip controller from a simple address request. It replaces bit-banged selection in the FPGA/test-harness build.
- A requester presents a target design address; the block disables the current design and resets or advances the controller's address counter with timed pulses.
- It then re-enables the design and reports the new selection.
- It tracks the currently selected address so that forward moves skip the counter reset.

---
 rtl/tt_sel_seq_if.sv | 27 ++
 rtl/tt_sel_seq.sv | 203 ++++++++++++++++++++
 tb/tb_tt_sel_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tt_sel_seq_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// tt_sel_seq_if : request/status bundle between a requester and tt_sel_seq
// Rev 1.0
//----------------------------------------------------------------------------
interface tt_sel_seq_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_en;
   logic              req_ready;
   logic              done;
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_valid;

   modport master (
      output req_valid, req_addr, req_en,
      input  req_ready, done, cur_addr, cur_valid
   );

   modport slave (
      input  req_valid, req_addr, req_en,
      output req_ready, done, cur_addr, cur_valid
   );
endinterface
`default_nettype wire

// File: rtl/tt_sel_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
// tt_sel_seq : drives TinyTapeout select pins (rst_n / inc / ena) from a request
// Rev 1.0
//----------------------------------------------------------------------------
module tt_sel_seq #(
   parameter int ADDR_W    = 10,
   parameter int PULSE_CYC = 4
) (
   input  logic         clk,
   input  logic         rst,
   tt_sel_seq_if.slave  req,
   output logic         ctrl_sel_rst_n,
   output logic         ctrl_sel_inc,
   output logic         ctrl_ena
);

   localparam logic [7:0] PH_LOAD = 8'(PULSE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DIS    = 3'd1,
      S_RST    = 3'd2,
      S_GAP    = 3'd3,
      S_INC_HI = 3'd4,
      S_INC_LO = 3'd5,
      S_FIN    = 3'd6
   } state_t;

   state_t            state, state_nx;
   logic [7:0]        phase, phase_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;
   logic [ADDR_W-1:0] tgt, tgt_nx;
   logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
   logic              en_l, en_nx;
   logic              full, full_nx;
   logic              ready, ready_nx;
   logic              done, done_nx;
   logic              cur_valid, cur_valid_nx;
   logic              sel_rst_n, sel_rst_n_nx;
   logic              sel_inc, sel_inc_nx;
   logic              ena, ena_nx;
   logic              phase_end;
   logic              go_inc;
   logic              go_fin;

   assign req.req_ready = ready;
   assign req.done      = done;
   assign req.cur_addr  = cur_addr;
   assign req.cur_valid = cur_valid;
   assign ctrl_sel_rst_n = sel_rst_n;
   assign ctrl_sel_inc   = sel_inc;
   assign ctrl_ena       = ena;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         phase     <= 8'd0;
         cnt       <= '0;
         tgt       <= '0;
         cur_addr  <= '0;
         en_l      <= 1'b0;
         full      <= 1'b0;
         ready     <= 1'b1;
         done      <= 1'b0;
         cur_valid <= 1'b0;
         sel_rst_n <= 1'b1;
         sel_inc   <= 1'b0;
         ena       <= 1'b0;
      end else begin
         state     <= state_nx;
         phase     <= phase_nx;
         cnt       <= cnt_nx;
         tgt       <= tgt_nx;
         cur_addr  <= cur_addr_nx;
         en_l      <= en_nx;
         full      <= full_nx;
         ready     <= ready_nx;
         done      <= done_nx;
         cur_valid <= cur_valid_nx;
         sel_rst_n <= sel_rst_n_nx;
         sel_inc   <= sel_inc_nx;
         ena       <= ena_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      phase_nx     = phase;
      cnt_nx       = cnt;
      tgt_nx       = tgt;
      cur_addr_nx  = cur_addr;
      en_nx        = en_l;
      full_nx      = full;
      ready_nx     = ready;
      done_nx      = 1'b0;
      cur_valid_nx = cur_valid;
      sel_rst_n_nx = sel_rst_n;
      sel_inc_nx   = sel_inc;
      ena_nx       = ena;
      phase_end    = (phase == 8'd0);
      go_inc       = 1'b0;
      go_fin       = 1'b0;

      case (state)
         S_IDLE: begin
            if (req.req_valid) begin
               tgt_nx   = req.req_addr;
               en_nx    = req.req_en;
               ready_nx = 1'b0;
               if (cur_valid && (req.req_addr == cur_addr)) begin
                  // Already selected: only the enable needs updating.
                  state_nx = S_FIN;
                  done_nx  = 1'b1;
                  ena_nx   = req.req_en;
               end else begin
                  state_nx     = S_DIS;
                  phase_nx     = PH_LOAD;
                  ena_nx       = 1'b0;
                  cur_valid_nx = 1'b0;
                  if (cur_valid && (req.req_addr > cur_addr)) begin
                     full_nx = 1'b0;
                     cnt_nx  = req.req_addr - cur_addr;
                  end else begin
                     full_nx = 1'b1;
                     cnt_nx  = req.req_addr;
                  end
               end
            end
         end
         S_DIS: begin
            if (!phase_end) begin
               phase_nx = phase - 8'd1;
            end else if (full) begin
               state_nx     = S_RST;
               sel_rst_n_nx = 1'b0;
               phase_nx     = PH_LOAD;
            end else begin
               go_inc = 1'b1;
            end
         end
         S_RST: begin
            if (!phase_end) begin
               phase_nx = phase - 8'd1;
            end else begin
               state_nx     = S_GAP;
               sel_rst_n_nx = 1'b1;
               phase_nx     = PH_LOAD;
            end
         end
         S_GAP: begin
            if (!phase_end) phase_nx = phase - 8'd1;
            else            go_inc   = 1'b1;
         end
         S_INC_HI: begin
            if (!phase_end) begin
               phase_nx = phase - 8'd1;
            end else begin
               state_nx   = S_INC_LO;
               sel_inc_nx = 1'b0;
               phase_nx   = PH_LOAD;
            end
         end
         S_INC_LO: begin
            if (!phase_end) begin
               phase_nx = phase - 8'd1;
            end else begin
               cnt_nx = cnt - ADDR_W'(1);
               go_inc = 1'b1;
            end
         end
         S_FIN: begin
            state_nx = S_IDLE;
            ready_nx = 1'b1;
         end
         default: begin
            state_nx = S_IDLE;
            ready_nx = 1'b1;
         end
      endcase

      // Shared entry into the increment loop; an exhausted count finishes instead.
      if (go_inc) begin
         if (cnt_nx == '0) begin
            go_fin = 1'b1;
         end else begin
            state_nx   = S_INC_HI;
            sel_inc_nx = 1'b1;
            phase_nx   = PH_LOAD;
         end
      end

      if (go_fin) begin
         state_nx     = S_FIN;
         done_nx      = 1'b1;
         ena_nx       = en_l;
         cur_addr_nx  = tgt;
         cur_valid_nx = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tt_sel_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_tt_sel_seq : directed + randomized bench for tt_sel_seq
// Rev 1.0
//----------------------------------------------------------------------------
module tb_tt_sel_seq;
   localparam int AW = 10;
   localparam int P  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel_rst_n, sel_inc, ena;

   always #5 clk = ~clk;

   tt_sel_seq_if #(.ADDR_W(AW)) bus ();

   tt_sel_seq #(.ADDR_W(AW), .PULSE_CYC(P)) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (bus),
      .ctrl_sel_rst_n (sel_rst_n),
      .ctrl_sel_inc   (sel_inc),
      .ctrl_ena       (ena)
   );

   int checks = 0;
   int errors = 0;
   int model_cur = 0;
   bit model_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},     32'(bus.req_ready), 1);
      check({tag, "_done"},      32'(bus.done),      0);
      check({tag, "_cur_addr"},  32'(bus.cur_addr),  0);
      check({tag, "_cur_valid"}, 32'(bus.cur_valid), 0);
      check({tag, "_rst_n"},     32'(sel_rst_n),     1);
      check({tag, "_inc"},       32'(sel_inc),       0);
      check({tag, "_ena"},       32'(ena),           0);
   endtask

   task automatic apply_reset(input int n, input string tag);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      repeat (n) @(negedge clk);
      check_reset_outputs(tag);
      rst = 1'b0;
      model_valid = 1'b0;
      model_cur   = 0;
   endtask

   // Issues one request and watches the pins until done; abort_pulse>0 returns
   // as soon as that increment pulse starts (caller then applies reset).
   task automatic do_req(input int addr, input logic en, input bit hold_busy,
                         input int abort_pulse, input string tag);
      bit fast, full;
      int exp_done, exp_pulses, wait_n;
      int done_at, pulses, rst_low, first_rst, hi_run, lo_run, shape_err, busy_err, ctr;
      logic prev_inc;

      fast = model_valid && (addr == model_cur);
      full = !model_valid || (addr < model_cur);
      if (fast) begin
         exp_done = 1;           exp_pulses = 0;
      end else if (full) begin
         exp_done = 3*P + 2*P*addr + 1;   exp_pulses = addr;
      end else begin
         exp_done = P + 2*P*(addr - model_cur) + 1;   exp_pulses = addr - model_cur;
      end

      done_at = 0; pulses = 0; rst_low = 0; first_rst = 0;
      hi_run = 0; lo_run = 0; shape_err = 0; busy_err = 0;
      ctr = model_cur; prev_inc = sel_inc;

      wait_n = 0;
      @(negedge clk);
      while (!bus.req_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      check({tag, "_ready_before"}, 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(addr);
      bus.req_en    = en;
      @(posedge clk);

      for (int k = 1; k <= exp_done + 50; k++) begin
         @(negedge clk);
         if (hold_busy) begin
            bus.req_addr = AW'($urandom);
            bus.req_en   = 1'($urandom);
         end else if (k == 1) begin
            bus.req_valid = 1'b0;
         end
         if (bus.req_ready) busy_err++;
         if (!fast && k <= P && ena) shape_err++;
         if (!sel_rst_n) begin
            rst_low++;
            if (first_rst == 0) first_rst = k;
            ctr = 0;
            if (sel_inc) shape_err++;
         end
         if (sel_inc) begin
            if (!prev_inc) begin
               pulses++;
               ctr++;
               if (pulses > 1 && lo_run != P) shape_err++;
               hi_run = 0;
            end
            hi_run++;
         end else begin
            if (prev_inc) begin
               if (hi_run != P) shape_err++;
               lo_run = 0;
            end
            lo_run++;
         end
         prev_inc = sel_inc;
         if (abort_pulse != 0 && pulses == abort_pulse) begin
            bus.req_valid = 1'b0;
            return;
         end
         if (bus.done) begin
            done_at = k;
            bus.req_valid = 1'b0;
            break;
         end
      end
      bus.req_valid = 1'b0;

      check({tag, "_done_cycle"}, 32'(done_at),   32'(exp_done));
      check({tag, "_inc_pulses"}, 32'(pulses),    32'(exp_pulses));
      check({tag, "_rst_low"},    32'(rst_low),   32'((full && !fast) ? P : 0));
      if (full && !fast)
         check({tag, "_rst_start"}, 32'(first_rst), 32'(P + 1));
      check({tag, "_shape"},      32'(shape_err), 0);
      check({tag, "_busy_ready"}, 32'(busy_err),  0);
      check({tag, "_cur_addr"},   32'(bus.cur_addr),  32'(addr));
      check({tag, "_cur_valid"},  32'(bus.cur_valid), 1);
      check({tag, "_ena"},        32'(ena),           32'(en));
      check({tag, "_counter"},    32'(ctr),           32'(addr));
      @(negedge clk);
      check({tag, "_ready_after"}, 32'(bus.req_ready), 1);
      check({tag, "_done_after"},  32'(bus.done),      0);
      model_cur   = addr;
      model_valid = 1'b1;
   endtask

   initial begin
      int a;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_en    = 1'b0;

      apply_reset(2, "reset");

      do_req(5, 1'b1, 1'b0, 0, "full5");
      do_req(7, 1'b1, 1'b0, 0, "incr7");
      do_req(3, 1'b1, 1'b0, 0, "back3");
      do_req(3, 1'b0, 1'b0, 0, "fast3");

      apply_reset(2, "reset2");
      do_req(0, 1'b1, 1'b0, 0, "zero");

      do_req(9, 1'b1, 1'b1, 0, "busy9");
      repeat (3) @(negedge clk);
      check("no_queue_done", 32'(bus.done), 0);
      check("no_queue_addr", 32'(bus.cur_addr), 9);

      do_req((1 << AW) - 1, 1'b1, 1'b0, 0, "max");

      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 3) == 0) a = model_cur;
         else                           a = int'($urandom_range(0, 40));
         do_req(a, 1'($urandom_range(0, 1)), 1'b0, 0, $sformatf("rand%0d", i));
      end

      apply_reset(1, "reset3");
      do_req(12, 1'b1, 1'b0, 3, "abort");
      rst = 1'b1;
      @(negedge clk);
      check("midrst_inc",       32'(sel_inc),       0);
      check("midrst_cur_valid", 32'(bus.cur_valid), 0);
      check("midrst_rst_n",     32'(sel_rst_n),     1);
      check("midrst_ena",       32'(ena),           0);
      check("midrst_ready",     32'(bus.req_ready), 1);
      rst = 1'b0;
      model_valid = 1'b0;
      model_cur   = 0;
      do_req(4, 1'b1, 1'b0, 0, "after_rst4");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
